// File: rtl/imm_ext_queue_pkg.sv
// Shared signal definitions for the immediate-extension queue: EXTOP mode codes and helpers.
package imm_ext_queue_pkg;

  typedef enum logic [2:0] {
    EXTOP_UNSIGNED = 3'd0,
    EXTOP_SIGNED   = 3'd1,
    EXTOP_INST     = 3'd2,
    EXTOP_UPPER    = 3'd3,
    EXTOP_BRANCH   = 3'd4
  } extop_e;

  localparam int unsigned ERR_CNT_W = 8;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/imm_ext_fifo.sv
// Result queue: DEPTH-entry circular buffer, no bypass when full, head forced to 0 when empty.
module imm_ext_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push, pop;

  always_comb begin
    wr_ready = (count_q < CNT_W'(DEPTH));
    rd_valid = (count_q != '0);
    push     = wr_valid && wr_ready;
    pop      = rd_valid && rd_ready;
    rd_data  = rd_valid ? mem[rptr_q] : '0;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/imm_ext_queue.sv
// Immediate extender feeding a result queue. Optional macro EXTOP_BRANCH_EN enables op 4
// (sign-extend, shift left 2); otherwise op 4 is illegal.
module imm_ext_queue
  import imm_ext_queue_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic [7:0]       err_cnt
);

  logic [OUT_W-1:0] zext, sext, ext;
  logic             ext_err;
  logic [OUT_W:0]   rd_data;
  logic [7:0]       err_cnt_q;

  always_comb begin
    zext    = {{(OUT_W - IN_W){1'b0}}, in_imm};
    sext    = {{(OUT_W - IN_W){in_imm[IN_W-1]}}, in_imm};
    ext     = '0;
    ext_err = 1'b0;
    case (in_op)
      EXTOP_UNSIGNED: ext = zext;
      EXTOP_SIGNED:   ext = sext;
      EXTOP_INST:     ext = '0;
      EXTOP_UPPER:    ext = {in_imm, {(OUT_W - IN_W){1'b0}}};
`ifdef EXTOP_BRANCH_EN
      EXTOP_BRANCH:   ext = sext << 2;
`endif
      default:        ext_err = 1'b1;
    endcase
  end

  imm_ext_fifo #(
    .WIDTH (OUT_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  ({ext_err, ext}),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (in_valid && in_ready && ext_err) begin
      err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  always_comb begin
    out_data = rd_data[OUT_W-1:0];
    out_err  = rd_data[OUT_W];
    err_cnt  = err_cnt_q;
  end

endmodule

// File: tb/tb_imm_ext_queue.sv
// Self-checking bench for imm_ext_queue: directed vector table, corner sequences, random traffic.
module tb_imm_ext_queue;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 32;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;
  logic [7:0]       err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of {err, data} entries and an error counter.
  logic [OUT_W:0] mq[$];
  int             m_err;

  typedef struct {
    logic [IN_W-1:0]  imm;
    logic [2:0]       op;
    logic [OUT_W-1:0] exp_data;
    logic             exp_err;
  } vec_t;

  vec_t tbl[10];

  imm_ext_queue #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [OUT_W:0] ref_ext(input logic [IN_W-1:0] imm, input logic [2:0] op);
    longint     u, s;
    logic [OUT_W-1:0] r;
    logic       e;
    u = longint'(imm);
    s = imm[IN_W-1] ? u - (longint'(1) << IN_W) : u;
    r = '0;
    e = 1'b0;
    case (op)
      3'd0: r = OUT_W'(u);
      3'd1: r = OUT_W'(s);
      3'd2: r = '0;
      3'd3: r = OUT_W'(u * (longint'(1) << (OUT_W - IN_W)));
`ifdef EXTOP_BRANCH_EN
      3'd4: r = OUT_W'(s * 4);
`endif
      default: e = 1'b1;
    endcase
    return {e, r};
  endfunction

  // Called at a falling edge: drive inputs, compare outputs against the model,
  // then advance the model and the DUT by one rising edge.
  task automatic cycle(input logic v, input logic [IN_W-1:0] imm, input logic [2:0] op,
                       input logic rdy);
    logic push, pop;
    logic [OUT_W:0] head;
    in_valid  = v;
    in_imm    = imm;
    in_op     = op;
    out_ready = rdy;
    #1;
    head = (mq.size() != 0) ? mq[0] : '0;
    check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    check("out_data", 64'(out_data), 64'(head[OUT_W-1:0]));
    check("out_err", 64'(out_err), 64'(head[OUT_W]));
    check("err_cnt", 64'(err_cnt), 64'(m_err));
    push = v && (mq.size() < DEPTH);
    pop  = rdy && (mq.size() != 0);
    if (pop) void'(mq.pop_front());
    if (push) begin
      logic [OUT_W:0] e;
      e = ref_ext(imm, op);
      mq.push_back(e);
      if (e[OUT_W] && m_err < 255) m_err++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset with an illegal push presented, which must be discarded.
  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_imm    = 16'h1234;
    in_op     = 3'd5;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    mq.delete();
    m_err = 0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
  endtask

  task automatic drain_count(input string name, input int exp);
    int n;
    n = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (out_valid) n++;
      cycle(1'b0, '0, 3'd0, 1'b1);
    end
    check(name, 64'(n), 64'(exp));
  endtask

  initial begin
    tbl[0] = '{16'h8001, 3'd1, 32'hFFFF8001, 1'b0};
    tbl[1] = '{16'h8001, 3'd0, 32'h00008001, 1'b0};
    tbl[2] = '{16'h1234, 3'd3, 32'h12340000, 1'b0};
    tbl[3] = '{16'hABCD, 3'd2, 32'h00000000, 1'b0};
`ifdef EXTOP_BRANCH_EN
    tbl[4] = '{16'hFFFF, 3'd4, 32'hFFFFFFFC, 1'b0};
`else
    tbl[4] = '{16'hFFFF, 3'd4, 32'h00000000, 1'b1};
`endif
    tbl[5] = '{16'h7FFF, 3'd1, 32'h00007FFF, 1'b0};
    tbl[6] = '{16'hFFFF, 3'd3, 32'hFFFF0000, 1'b0};
    tbl[7] = '{16'h1234, 3'd5, 32'h00000000, 1'b1};
    tbl[8] = '{16'h00FF, 3'd6, 32'h00000000, 1'b1};
    tbl[9] = '{16'hFFFF, 3'd7, 32'h00000000, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_imm = '0; in_op = '0; out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Directed vectors: push into empty queue, head valid one cycle later.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, tbl[i].imm, tbl[i].op, 1'b1);
      in_valid = 1'b0;
      #1;
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_data", i), 64'(out_data), 64'(tbl[i].exp_data));
      check($sformatf("vec%0d_err", i), 64'(out_err), 64'(tbl[i].exp_err));
      cycle(1'b0, '0, 3'd0, 1'b1);
    end

    // Fill with out_ready low: in_ready drops after the 4th push, 5th is held.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'(16'h100 + i), 3'd0, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 3'd0, 1'b1);
    check("drained_valid", 64'(out_valid), 64'd0);

    // Full queue with push+pop: pop wins, push refused, three remain.
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'(16'h200 + i), 3'd1, 1'b0);
    cycle(1'b1, 16'h0BAD, 3'd0, 1'b1);
    check("after_full_pp_ready", 64'(in_ready), 64'd1);
    drain_count("full_pp_count", 3);

    // Steady half-full push+pop keeps occupancy constant.
    cycle(1'b1, 16'h0011, 3'd0, 1'b0);
    cycle(1'b1, 16'h0022, 3'd0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'($urandom()), 3'(i % 4), 1'b1);
    drain_count("steady_count", 2);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) cycle(1'b1, 16'($urandom()), 3'(5 + (i % 3)), 1'b1);
    cycle(1'b0, '0, 3'd0, 1'b1);
    check("err_cnt_sat", 64'(err_cnt), 64'd255);

    // Reset with three entries queued flushes everything.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'(16'h300 + i), 3'd0, 1'b0);
    do_reset();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom()), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_ext_queue.md
IMM_EXT_QUEUE -- requirements
Module: imm_ext_queue

Interface
REQ-001 Parameter IN_W, default 16, immediate input width; legal values are 2 or more.
REQ-002 Parameter OUT_W, default 32, extended output width; OUT_W SHALL be at least IN_W+2.
REQ-003 Parameter DEPTH, default 4, result queue entries; DEPTH SHALL be a power of two and at least 2.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  producer offers an immediate.
REQ-007 in_ready  output  1  queue can accept an immediate this cycle.
REQ-008 in_imm  input  IN_W  raw immediate field.
REQ-009 in_op  input  3  EXTOP extension mode code.
REQ-010 out_valid  output  1  head entry is valid.
REQ-011 out_ready  input  1  consumer takes the head entry.
REQ-012 out_data  output  OUT_W  extended value at the head.
REQ-013 out_err  output  1  head entry came from an illegal op.
REQ-014 err_cnt  output  8  saturating count of accepted illegal ops.

Function
REQ-015 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-016 in_ready SHALL be (count < DEPTH); when the queue is full there SHALL be no same-cycle bypass, even if a pop occurs.
REQ-017 out_valid SHALL be (count != 0); out_data and out_err SHALL show the head entry and SHALL hold stable while out_valid && !out_ready.
REQ-018 Latency SHALL be 1 cycle: an entry pushed in cycle N is visible at the head in cycle N+1 if the queue was empty.
REQ-019 The extension SHALL be computed at push time from in_imm and in_op and stored with a 1-bit error flag.
REQ-020 Op 0 UNSIGNED: zero-extend in_imm to OUT_W.
REQ-021 Op 1 SIGNED: sign-extend from in_imm[IN_W-1].
REQ-022 Op 2 INST: the stored value is all zeros and the error flag is 0.
REQ-023 Op 3 UPPER: in_imm SHALL occupy out bits [OUT_W-1:OUT_W-IN_W], and the low bits are zero.
REQ-024 Op 4 BRANCH: sign-extend, then shift left by 2 and truncate to OUT_W (see REQ-033).
REQ-025 Ops 5-7 are illegal: the stored value is zero, the error flag is 1, and err_cnt increments.
REQ-026 err_cnt SHALL saturate at 255 and SHALL clear only on rst.
REQ-027 A simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged.
REQ-028 The read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH.

Reset
REQ-029 When rst is high at a clock edge, count, both pointers and err_cnt SHALL be set to 0.
REQ-030 While and after reset, out_valid SHALL be 0, in_ready SHALL be 1, out_data SHALL be 0 and out_err SHALL be 0.
REQ-031 A reset during operation SHALL flush every queued entry; a push presented in the reset cycle SHALL be discarded.
REQ-032 Queue storage need not be reset; out_data SHALL be forced to 0 while count == 0.

Configuration
REQ-033 Macro EXTOP_BRANCH_EN: when defined, op 4 behaves as specified in REQ-024.
REQ-034 When EXTOP_BRANCH_EN is undefined, op 4 SHALL be treated as illegal, as specified in REQ-025.

Structure
REQ-035 The EXTOP_UNSIGNED/SIGNED/INST/UPPER/BRANCH codes SHALL live in the shared signal definitions package alongside the existing EXTOP codes.
REQ-036 Storage, pointers and count SHALL be a sub-module imm_ext_fifo, parametrised by width OUT_W+1 and by DEPTH.
REQ-037 The extension logic SHALL be combinational in the top level, feeding the fifo write data.

Verification
REQ-038 SIGNED 0x8001, out_ready=1 -> out_data 0xFFFF8001 one cycle later, out_err 0.
REQ-039 UNSIGNED 0x8001 -> 0x00008001; UPPER 0x1234 -> 0x12340000; INST 0xABCD -> 0x00000000.
REQ-040 BRANCH 0xFFFF with the macro defined -> 0xFFFFFFFC; without the macro -> 0x00000000, out_err 1, err_cnt 1.
REQ-041 DEPTH=4, out_ready=0, 5 back-to-back pushes -> in_ready drops after the 4th push and the 5th is held.
REQ-041 (cont.) Then out_ready=1 -> the four entries emerge in order, one per cycle.
REQ-042 Full queue with push and pop in the same cycle -> the pop succeeds, the push is refused and count becomes 3.
REQ-042 (cont.) Steady half-full push+pop -> count stays constant.
REQ-043 260 illegal pushes -> err_cnt sticks at 255.
REQ-043 (cont.) rst asserted with 3 entries queued -> out_valid 0 next cycle, err_cnt 0, in_ready 1.
